// File: rtl/length_burst_sequencer.sv
// length_burst_sequencer: reads a burst of `length` words from on-chip memory,
// one read outstanding at a time, and streams them out over valid/ready.
// The start level, busy and done form a software handshake with the HPS.
module length_burst_sequencer #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        length,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [6:0]        count
);

    localparam int unsigned LEN_W  = 7;
    localparam int unsigned WAIT_W = 3;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                start_q;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    count_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                rd_d;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;
    logic                start_edge;
    logic                last_word;

    // Rising edge of the start level; start_q tracks start every cycle.
    assign start_edge = start & ~start_q;
    // The word being presented is the final one of the burst.
    assign last_word  = (count + LEN_W'(1)) == len_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count;
        wait_d  = wait_q;
        addr_d  = mem_address;
        rd_d    = 1'b0;
        data_d  = out_data;
        valid_d = out_valid;
        busy_d  = busy;
        done_d  = done;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    len_d   = length;
                    count_d = '0;
                    busy_d  = 1'b1;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        rd_d    = 1'b1;
                        addr_d  = BASE;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    data_d  = mem_readdata;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_PRESENT: begin
                if (out_valid && out_ready) begin
                    valid_d = 1'b0;
                    count_d = count + LEN_W'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Word index equals words delivered; address wraps modulo 2^ADDR_W.
                        state_d = S_READ;
                        rd_d    = 1'b1;
                        addr_d  = BASE + ADDR_W'(count_d);
                    end
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            len_q       <= '0;
            count       <= '0;
            wait_q      <= '0;
            mem_address <= BASE;
            mem_read    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            len_q       <= len_d;
            count       <= count_d;
            wait_q      <= wait_d;
            mem_address <= addr_d;
            mem_read    <= rd_d;
            out_data    <= data_d;
            out_valid   <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_length_burst_sequencer.sv
// Bench for length_burst_sequencer: two instances (base 0 / latency 1 and
// base 126 / latency 2) share stimulus; each has a memory model and a
// transfer-phase reference model that checks every cycle.
module tb_length_burst_sequencer;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NLANE  = 2;
    localparam int unsigned LANE_BASE [NLANE] = '{0, 126};
    localparam int unsigned LANE_LAT  [NLANE] = '{1, 2};

    typedef enum logic [1:0] {M_IDLE, M_ZERO, M_RUN, M_DONE} mphase_e;

    typedef struct {
        int unsigned len;
        int          stall_at;   // word index to hold off, -1 for none
        int unsigned stall_len;  // valid cycles with ready low
        int          mid_len;    // -1, or length rewritten + start re-pulsed mid-burst
        int unsigned exp_words;
        logic [31:0] exp_last;   // last word seen on lane 0
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        out_ready;
    logic [6:0]  length;
    logic [31:0] data_key;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [ADDR_W-1:0] addr_w  [NLANE];
    logic              rd_w    [NLANE];
    logic [31:0]       data_w  [NLANE];
    logic              valid_w [NLANE];
    logic              busy_w  [NLANE];
    logic              done_w  [NLANE];
    logic [6:0]        count_w [NLANE];
    logic [31:0]       hs_w    [NLANE];
    logic [31:0]       rdn_w   [NLANE];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input int unsigned a);
        return data_key ^ (32'h100 + a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        localparam int unsigned BASE = LANE_BASE[k];
        localparam int unsigned LAT  = LANE_LAT[k];

        logic [ADDR_W-1:0] mem_address;
        logic              mem_read;
        logic [31:0]       mem_readdata;
        logic [31:0]       out_data;
        logic              out_valid;
        logic              busy;
        logic              done;
        logic [6:0]        count;
        logic [31:0]       pipe [LAT];
        mphase_e           ph;
        mphase_e           nx;
        int unsigned       hs_n;
        int unsigned       rd_n;
        int unsigned       n_m;
        logic              start_m;

        length_burst_sequencer #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .RD_LATENCY(LAT),
            .BASE_ADDR (BASE)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .length      (length),
            .start       (start),
            .mem_address (mem_address),
            .mem_read    (mem_read),
            .mem_readdata(mem_readdata),
            .out_data    (out_data),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .busy        (busy),
            .done        (done),
            .count       (count)
        );

        // Memory: data appears LAT cycles after the read strobe, junk otherwise.
        always @(posedge clk) begin
            pipe[0] <= mem_read ? mem_val(32'(mem_address)) : 32'hDEAD_BEEF;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
        assign mem_readdata = pipe[LAT-1];

        assign addr_w[k]  = mem_address;
        assign rd_w[k]    = mem_read;
        assign data_w[k]  = out_data;
        assign valid_w[k] = out_valid;
        assign busy_w[k]  = busy;
        assign done_w[k]  = done;
        assign count_w[k] = count;
        assign hs_w[k]    = hs_n;
        assign rdn_w[k]   = rd_n;

        // Transfer-phase reference: word j comes from BASE+j, one read per word.
        always @(negedge clk) begin
            if (reset) begin
                ph = M_IDLE; start_m = 1'b0; hs_n = 0; rd_n = 0; n_m = 0;
            end else begin
                nx = ph;
                check($sformatf("lane%0d_busy", k), 32'(busy), 32'(ph == M_RUN || ph == M_ZERO));
                check($sformatf("lane%0d_done", k), 32'(done), 32'(ph == M_DONE));
                check($sformatf("lane%0d_count", k), 32'(count), hs_n);
                if (mem_read) begin
                    check($sformatf("lane%0d_rd_phase", k), 32'(ph == M_RUN), 32'd1);
                    check($sformatf("lane%0d_rd_single", k), rd_n, hs_n);
                    check($sformatf("lane%0d_rd_addr", k), 32'(mem_address), (BASE + rd_n) % 128);
                    rd_n++;
                end
                if (out_valid) begin
                    check($sformatf("lane%0d_valid_phase", k), 32'(ph == M_RUN), 32'd1);
                    check($sformatf("lane%0d_data", k), out_data, mem_val((BASE + hs_n) % 128));
                    if (out_ready) begin
                        check($sformatf("lane%0d_extra_word", k), 32'(hs_n < n_m), 32'd1);
                        hs_n++;
                        if (hs_n == n_m) nx = M_DONE;
                    end
                end
                case (ph)
                    M_IDLE: if (start && !start_m) begin
                        n_m  = 32'(length);
                        hs_n = 0;
                        rd_n = 0;
                        nx   = (length == 7'd0) ? M_ZERO : M_RUN;
                    end
                    M_ZERO: nx = start ? M_DONE : M_IDLE;
                    M_DONE: if (!start) nx = M_IDLE;
                    default: ;
                endcase
                ph      = nx;
                start_m = start;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one transfer, drive ready, wait for done, then release start.
    task automatic run_vec(input vec_t v, input bit rnd);
        int unsigned stalled;
        bit          finished;
        stalled  = 0;
        finished = 1'b0;
        length    = 7'(v.len);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (v.mid_len >= 0 && cyc == 3) begin
                length = 7'(v.mid_len);
                start  = 1'b0;
            end
            if (v.mid_len >= 0 && cyc == 4) start = 1'b1;
            if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (valid_w[0] && v.stall_at >= 0 && int'(hs_w[0]) == v.stall_at
                         && stalled < v.stall_len) begin
                out_ready = 1'b0;
                stalled++;
                check("bp_hold_data", data_w[0], 32'h100 + 32'(v.stall_at));
            end else begin
                out_ready = 1'b1;
            end
            if (done_w[0] && done_w[1]) begin
                finished = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(finished), 32'd1);
        for (int k = 0; k < int'(NLANE); k++) begin
            check($sformatf("lane%0d_words", k), hs_w[k], v.exp_words);
            check($sformatf("lane%0d_reads", k), rdn_w[k], v.exp_words);
            check($sformatf("lane%0d_final_count", k), 32'(count_w[k]), v.exp_words);
        end
        if (v.exp_words > 0) check("lane0_last_data", data_w[0], v.exp_last);
        out_ready = 1'b1;
        repeat (3) step();
        check("done_held", 32'(done_w[0] & done_w[1]), 32'd1);
        start = 1'b0;
        step();
        check("done_cleared", 32'(done_w[0] | done_w[1]), 32'd0);
        step();
    endtask

    initial begin
        vec_t        tbl [6];
        vec_t        rv;
        int unsigned n;
        bit          ok;

        tbl[0] = '{4,   -1, 0, -1, 4,   32'h103};
        tbl[1] = '{3,    1, 5, -1, 3,   32'h102};
        tbl[2] = '{0,   -1, 0, -1, 0,   32'h0};
        tbl[3] = '{2,   -1, 0,  9, 2,   32'h101};
        tbl[4] = '{9,   -1, 0, -1, 9,   32'h108};
        tbl[5] = '{127, -1, 0, -1, 127, 32'h17E};

        reset = 1'b1; start = 1'b0; length = 7'd0; out_ready = 1'b1; data_key = 32'h0;
        repeat (3) step();
        for (int k = 0; k < int'(NLANE); k++) begin
            check($sformatf("rst%0d_addr", k), 32'(addr_w[k]), LANE_BASE[k]);
            check($sformatf("rst%0d_read", k), 32'(rd_w[k]), 32'd0);
            check($sformatf("rst%0d_data", k), data_w[k], 32'd0);
            check($sformatf("rst%0d_valid", k), 32'(valid_w[k]), 32'd0);
            check($sformatf("rst%0d_busy", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("rst%0d_done", k), 32'(done_w[k]), 32'd0);
            check($sformatf("rst%0d_count", k), 32'(count_w[k]), 32'd0);
        end
        reset = 1'b0;
        step();

        // Directed table.
        for (int i = 0; i < 6; i++) run_vec(tbl[i], 1'b0);

        // Reset in the middle of a 10-word burst.
        length = 7'd10; start = 1'b1; out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (hs_w[0] >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_mid_reach", 32'(ok), 32'd1);
        reset = 1'b1; start = 1'b0;
        step();
        for (int k = 0; k < int'(NLANE); k++) begin
            check($sformatf("rst_mid%0d_busy", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("rst_mid%0d_done", k), 32'(done_w[k]), 32'd0);
            check($sformatf("rst_mid%0d_count", k), 32'(count_w[k]), 32'd0);
            check($sformatf("rst_mid%0d_valid", k), 32'(valid_w[k]), 32'd0);
            check($sformatf("rst_mid%0d_read", k), 32'(rd_w[k]), 32'd0);
            check($sformatf("rst_mid%0d_addr", k), 32'(addr_w[k]), LANE_BASE[k]);
        end
        step();
        check("rst_hold_read", 32'(rd_w[0] | rd_w[1]), 32'd0);
        reset = 1'b0;
        step();
        run_vec('{10, -1, 0, -1, 10, 32'h109}, 1'b0);

        // Reset and start edge in the same cycle: the edge is lost.
        reset = 1'b1; start = 1'b1;
        step();
        check("rst_edge_busy", 32'(busy_w[0] | busy_w[1]), 32'd0);
        reset = 1'b0; start = 1'b0;
        step();
        step();
        check("rst_edge_idle", 32'(busy_w[0] | busy_w[1] | done_w[0] | done_w[1]), 32'd0);

        // Randomized bursts, random data and backpressure.
        for (int t = 0; t < 12; t++) begin
            data_key = $urandom;
            n = $urandom_range(0, 24);
            rv = '{n, -1, 0, -1, n, (n > 0) ? mem_val(n - 1) : 32'h0};
            run_vec(rv, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
